inst_encoder: RTL and testbench

//  RV32I instruction encoder: the inverse of the pipeline's control decoder. Accepts a mnemonic ID

---
 rtl/inst_enc_pkg.sv | 80 ++++++++
 rtl/inst_pack.sv | 57 +++++
 rtl/inst_encoder.sv | 98 +++++++++
 tb/tb_inst_encoder.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_enc_pkg.sv
// RV32I encoder shared definitions: mnemonic IDs, major opcodes and the
// per-mnemonic field lookup used by the instruction packer.
package inst_enc_pkg;

  typedef enum logic [5:0] {
    MN_ADD = 6'd0, MN_SUB, MN_OR, MN_AND, MN_SLT, MN_SLTU, MN_XOR, MN_SLL, MN_SRL, MN_SRA,
    MN_ADDI, MN_ORI, MN_ANDI, MN_SLTI, MN_SLTIU, MN_XORI, MN_SLLI, MN_SRLI, MN_SRAI,
    MN_LB, MN_LH, MN_LW, MN_LBU, MN_LHU, MN_SB, MN_SH, MN_SW,
    MN_BEQ, MN_BNE, MN_BLT, MN_BGE, MN_BLTU, MN_BGEU, MN_JAL, MN_JALR, MN_LUI, MN_AUIPC
  } mn_e;

  typedef enum logic [2:0] {FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
  } enc_t;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // Undefined IDs fall through to FMT_NONE, which the packer treats as a reject.
  function automatic enc_t lookup(input logic [5:0] mn);
    enc_t e;
    e = '{FMT_NONE, 7'd0, 3'd0, 7'd0};
    case (mn)
      MN_ADD:   e = '{FMT_R,  OP_REG,    3'b000, 7'd0};
      MN_SUB:   e = '{FMT_R,  OP_REG,    3'b000, F7_ALT};
      MN_OR:    e = '{FMT_R,  OP_REG,    3'b110, 7'd0};
      MN_AND:   e = '{FMT_R,  OP_REG,    3'b111, 7'd0};
      MN_SLT:   e = '{FMT_R,  OP_REG,    3'b010, 7'd0};
      MN_SLTU:  e = '{FMT_R,  OP_REG,    3'b011, 7'd0};
      MN_XOR:   e = '{FMT_R,  OP_REG,    3'b100, 7'd0};
      MN_SLL:   e = '{FMT_R,  OP_REG,    3'b001, 7'd0};
      MN_SRL:   e = '{FMT_R,  OP_REG,    3'b101, 7'd0};
      MN_SRA:   e = '{FMT_R,  OP_REG,    3'b101, F7_ALT};
      MN_ADDI:  e = '{FMT_I,  OP_IMM,    3'b000, 7'd0};
      MN_ORI:   e = '{FMT_I,  OP_IMM,    3'b110, 7'd0};
      MN_ANDI:  e = '{FMT_I,  OP_IMM,    3'b111, 7'd0};
      MN_SLTI:  e = '{FMT_I,  OP_IMM,    3'b010, 7'd0};
      MN_SLTIU: e = '{FMT_I,  OP_IMM,    3'b011, 7'd0};
      MN_XORI:  e = '{FMT_I,  OP_IMM,    3'b100, 7'd0};
      MN_SLLI:  e = '{FMT_SH, OP_IMM,    3'b001, 7'd0};
      MN_SRLI:  e = '{FMT_SH, OP_IMM,    3'b101, 7'd0};
      MN_SRAI:  e = '{FMT_SH, OP_IMM,    3'b101, F7_ALT};
      MN_LB:    e = '{FMT_I,  OP_LOAD,   3'b000, 7'd0};
      MN_LH:    e = '{FMT_I,  OP_LOAD,   3'b001, 7'd0};
      MN_LW:    e = '{FMT_I,  OP_LOAD,   3'b010, 7'd0};
      MN_LBU:   e = '{FMT_I,  OP_LOAD,   3'b100, 7'd0};
      MN_LHU:   e = '{FMT_I,  OP_LOAD,   3'b101, 7'd0};
      MN_SB:    e = '{FMT_S,  OP_STORE,  3'b000, 7'd0};
      MN_SH:    e = '{FMT_S,  OP_STORE,  3'b001, 7'd0};
      MN_SW:    e = '{FMT_S,  OP_STORE,  3'b010, 7'd0};
      MN_BEQ:   e = '{FMT_B,  OP_BRANCH, 3'b000, 7'd0};
      MN_BNE:   e = '{FMT_B,  OP_BRANCH, 3'b001, 7'd0};
      MN_BLT:   e = '{FMT_B,  OP_BRANCH, 3'b100, 7'd0};
      MN_BGE:   e = '{FMT_B,  OP_BRANCH, 3'b101, 7'd0};
      MN_BLTU:  e = '{FMT_B,  OP_BRANCH, 3'b110, 7'd0};
      MN_BGEU:  e = '{FMT_B,  OP_BRANCH, 3'b111, 7'd0};
      MN_JAL:   e = '{FMT_J,  OP_JAL,    3'b000, 7'd0};
      MN_JALR:  e = '{FMT_I,  OP_JALR,   3'b000, 7'd0};
      MN_LUI:   e = '{FMT_U,  OP_LUI,    3'b000, 7'd0};
      MN_AUIPC: e = '{FMT_U,  OP_AUIPC,  3'b000, 7'd0};
      default:  e = '{FMT_NONE, 7'd0, 3'd0, 7'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational RV32I field packer with immediate range checks; rejected
// requests produce the canonical NOP and raise bad.
module inst_pack
  import inst_enc_pkg::*;
(
  input  logic [5:0]  mn,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  enc_t enc;
  logic fits_i, fits_b, fits_j, fits_sh;

  assign enc = lookup(mn);

  // Sign-extension checks: upper bits must all equal the top payload bit.
  assign fits_i  = (imm[31:11] == {21{imm[11]}});
  assign fits_b  = (imm[31:12] == {20{imm[12]}}) && !imm[0];
  assign fits_j  = (imm[31:20] == {12{imm[20]}}) && !imm[0];
  assign fits_sh = (imm[31:5] == 27'd0);

  always_comb begin
    word = NOP_WORD;
    bad  = 1'b0;
    case (enc.fmt)
      FMT_R: word = {enc.f7, rs2, rs1, enc.f3, rd, enc.opcode};
      FMT_I: begin
        bad  = !fits_i;
        word = {imm[11:0], rs1, enc.f3, rd, enc.opcode};
      end
      FMT_SH: begin
        bad  = !fits_sh;
        word = {enc.f7, imm[4:0], rs1, enc.f3, rd, enc.opcode};
      end
      FMT_S: begin
        bad  = !fits_i;
        word = {imm[11:5], rs2, rs1, enc.f3, imm[4:0], enc.opcode};
      end
      FMT_B: begin
        bad  = !fits_b;
        word = {imm[12], imm[10:5], rs2, rs1, enc.f3, imm[4:1], imm[11], enc.opcode};
      end
      FMT_U: word = {imm[31:12], rd, enc.opcode};
      FMT_J: begin
        bad  = !fits_j;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, enc.opcode};
      end
      default: bad = 1'b1;
    endcase
    if (bad) word = NOP_WORD;
  end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder front end: valid/ready request intake, single output
// register toward instruction memory, auto-incrementing address and sticky error.
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int            AW        = 10,
  parameter logic [AW-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    req_mn,
  input  logic [4:0]    req_rd,
  input  logic [4:0]    req_rs1,
  input  logic [4:0]    req_rs2,
  input  logic [31:0]   req_imm,
  output logic          im_we,
  input  logic          im_ready,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          err,
  output logic [AW-2:0] word_cnt
);

  logic          im_we_q, im_we_d;
  logic [AW-1:0] im_addr_q, im_addr_d;
  logic [31:0]   im_wdata_q, im_wdata_d;
  logic          err_q, err_d;
  logic [AW-2:0] word_cnt_q, word_cnt_d;
  logic [31:0]   pack_word;
  logic          pack_bad;
  logic          accept, done;

  inst_pack u_pack (
    .mn   (req_mn),
    .rd   (req_rd),
    .rs1  (req_rs1),
    .rs2  (req_rs2),
    .imm  (req_imm),
    .word (pack_word),
    .bad  (pack_bad)
  );

  assign req_ready = ~rst & ~start & (~im_we_q | im_ready);
  assign accept    = req_valid & req_ready;
  assign done      = im_we_q & im_ready;

  // im_addr_q always names the slot of the word in (or next into) the output register,
  // so a request accepted alongside a completing write lands on the bumped address.
  always_comb begin
    im_we_d    = im_we_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    err_d      = err_q;
    word_cnt_d = word_cnt_q;
    if (done) begin
      im_we_d    = 1'b0;
      im_addr_d  = im_addr_q + AW'(4);
      word_cnt_d = word_cnt_q + (AW-1)'(1);
    end
    if (accept) begin
      im_we_d    = 1'b1;
      im_wdata_d = pack_word;
      err_d      = err_q | pack_bad;
    end
    if (start) begin
      im_we_d    = 1'b0;
      im_addr_d  = BASE_ADDR;
      err_d      = 1'b0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      im_we_q    <= 1'b0;
      im_addr_q  <= BASE_ADDR;
      im_wdata_q <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign err      = err_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios plus a randomized run
// against an arithmetic reference model of the encoding and the write stream.
module tb_inst_encoder;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst, start, req_valid, req_ready, im_we, im_ready, err;
  logic [5:0]    req_mn;
  logic [4:0]    req_rd, req_rs1, req_rs2;
  logic [31:0]   req_imm, im_wdata;
  logic [AW-1:0] im_addr;
  logic [AW-2:0] word_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic        m_we, m_err;
  int          m_addr, m_cnt;
  logic [31:0] m_word;

  always #5 clk = ~clk;

  inst_encoder #(.AW(AW), .BASE_ADDR(10'h000)) dut (
    .clk(clk), .rst(rst), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .req_mn(req_mn), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr), .im_wdata(im_wdata),
    .err(err), .word_cnt(word_cnt)
  );

  // Reference encoder: fields placed by weighted sums, ranges checked on signed integers.
  function automatic void ref_encode(input int mn, input int rd, input int rs1, input int rs2,
                                     input int imm, output logic [31:0] w, output logic bad);
    int r_f3[10];
    int i_f3[6];
    int l_f3[5];
    int b_f3[6];
    longint S7, S8, S12, S15, S20, S21, S25, S31, v;
    r_f3 = '{0, 0, 6, 7, 2, 3, 4, 1, 5, 5};
    i_f3 = '{0, 6, 7, 2, 3, 4};
    l_f3 = '{0, 1, 2, 4, 5};
    b_f3 = '{0, 1, 4, 5, 6, 7};
    S7 = 128; S8 = 256; S12 = 4096; S15 = 32768; S20 = 1 << 20; S21 = 1 << 21;
    S25 = 1 << 25; S31 = 64'h8000_0000;
    bad = 1'b0;
    v = 0;
    if (mn <= 9) begin
      v = ((mn == 1 || mn == 9) ? 32 : 0) * S25 + rs2 * S20 + rs1 * S15 + r_f3[mn] * S12 + rd * S7 + 51;
    end else if (mn <= 15 || (mn >= 19 && mn <= 23) || mn == 34) begin
      bad = (imm < -2048 || imm > 2047);
      v = longint'(imm & 4095) * S20 + rs1 * S15 + rd * S7;
      if (mn <= 15)      v = v + i_f3[mn-10] * S12 + 19;
      else if (mn == 34) v = v + 103;
      else               v = v + l_f3[mn-19] * S12 + 3;
    end else if (mn <= 18) begin
      bad = (imm < 0 || imm > 31);
      v = ((mn == 18) ? 32 : 0) * S25 + longint'(imm & 31) * S20 + rs1 * S15
          + ((mn == 16) ? 1 : 5) * S12 + rd * S7 + 19;
    end else if (mn <= 26) begin
      bad = (imm < -2048 || imm > 2047);
      v = longint'((imm >>> 5) & 127) * S25 + rs2 * S20 + rs1 * S15 + (mn - 24) * S12
          + longint'(imm & 31) * S7 + 35;
    end else if (mn <= 32) begin
      bad = (imm < -4096 || imm > 4094 || (imm % 2) != 0);
      v = longint'((imm >>> 12) & 1) * S31 + longint'((imm >>> 5) & 63) * S25 + rs2 * S20
          + rs1 * S15 + b_f3[mn-27] * S12 + longint'((imm >>> 1) & 15) * S8
          + longint'((imm >>> 11) & 1) * S7 + 99;
    end else if (mn == 33) begin
      bad = (imm < -(1 << 20) || imm > (1 << 20) - 2 || (imm % 2) != 0);
      v = longint'((imm >>> 20) & 1) * S31 + longint'((imm >>> 1) & 1023) * S21
          + longint'((imm >>> 11) & 1) * S20 + longint'((imm >>> 12) & 255) * S12 + rd * S7 + 111;
    end else if (mn == 35 || mn == 36) begin
      v = (longint'(imm) & 64'hFFFF_F000) + rd * S7 + ((mn == 35) ? 55 : 23);
    end else begin
      bad = 1'b1;
    end
    w = bad ? 32'h0000_0013 : v[31:0];
  endfunction

  // Advance one clock, stepping the model with the inputs currently driven.
  task automatic tick();
    logic rdy, acc, b;
    logic [31:0] w;
    rdy = !rst && !start && (!m_we || im_ready);
    acc = req_valid && rdy;
    ref_encode(int'(req_mn), int'(req_rd), int'(req_rs1), int'(req_rs2), int'(req_imm), w, b);
    if (acc)
      $display("txn mn=%0d rd=%0d rs1=%0d rs2=%0d imm=%h -> word=%h bad=%0d",
               req_mn, req_rd, req_rs1, req_rs2, req_imm, w, b);
    @(posedge clk);
    if (rst || start) begin
      m_we = 1'b0; m_addr = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (m_we && im_ready) begin
        m_we = 1'b0; m_addr = (m_addr + 4) % 1024; m_cnt = (m_cnt + 1) % 512;
      end
      if (acc) begin
        m_we = 1'b1; m_word = w; m_err = m_err | b;
      end
    end
    #1;
  endtask

  task automatic set_req(input logic v, input int mn, input int rd, input int rs1, input int rs2,
                         input logic [31:0] imm);
    req_valid = v;
    req_mn    = 6'(mn);
    req_rd    = 5'(rd);
    req_rs1   = 5'(rs1);
    req_rs2   = 5'(rs2);
    req_imm   = imm;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; im_ready = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 32'd0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; im_ready = 1'b1;
    set_req(1'b1, 0, 1, 2, 3, 32'd0);
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready); else n_pass++;
    tick();
    n_checks++; if (im_we !== 1'b0) $display("FAIL reset_we: got %b want 0", im_we); else n_pass++;
    n_checks++; if (im_addr !== 10'h000) $display("FAIL reset_addr: got %h want 000", im_addr); else n_pass++;
    n_checks++; if (im_wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    n_checks++; if (word_cnt !== 9'd0) $display("FAIL reset_cnt: got %0d want 0", word_cnt); else n_pass++;
    rst = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 32'd0);
    tick();
  endtask

  task automatic test_add();
    do_reset();
    im_ready = 1'b1;
    set_req(1'b1, 0, 1, 2, 3, 32'd0);
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL add_ready: got %b want 1", req_ready); else n_pass++;
    tick();
    req_valid = 1'b0;
    n_checks++; if (im_we !== 1'b1) $display("FAIL add_we: got %b want 1", im_we); else n_pass++;
    n_checks++; if (im_addr !== 10'h000) $display("FAIL add_addr: got %h want 000", im_addr); else n_pass++;
    n_checks++; if (im_wdata !== 32'h003100B3) $display("FAIL add_wdata: got %h want 003100b3", im_wdata); else n_pass++;
    tick();
    n_checks++; if (im_we !== 1'b0) $display("FAIL add_we_clear: got %b want 0", im_we); else n_pass++;
    n_checks++; if (word_cnt !== 9'd1) $display("FAIL add_cnt: got %0d want 1", word_cnt); else n_pass++;
    n_checks++; if (im_addr !== 10'h004) $display("FAIL add_next_addr: got %h want 004", im_addr); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    im_ready = 1'b1;
    set_req(1'b1, 10, 5, 0, 0, 32'hFFFF_FFFF);
    tick();
    n_checks++; if (im_wdata !== 32'hFFF00293 || im_addr !== 10'h000 || im_we !== 1'b1)
      $display("FAIL b2b_addi: got we=%b %h@%h want 1 fff00293@000", im_we, im_wdata, im_addr); else n_pass++;
    set_req(1'b1, 26, 0, 2, 6, 32'd8);
    tick();
    n_checks++; if (im_wdata !== 32'h00612423 || im_addr !== 10'h004 || im_we !== 1'b1)
      $display("FAIL b2b_sw: got we=%b %h@%h want 1 00612423@004", im_we, im_wdata, im_addr); else n_pass++;
    req_valid = 1'b0;
    tick();
    n_checks++; if (word_cnt !== 9'd2) $display("FAIL b2b_cnt: got %0d want 2", word_cnt); else n_pass++;
    n_checks++; if (im_we !== 1'b0) $display("FAIL b2b_idle: got %b want 0", im_we); else n_pass++;
  endtask

  task automatic test_branch_err();
    do_reset();
    im_ready = 1'b1;
    set_req(1'b1, 27, 0, 1, 2, 32'hFFFF_FFFC);
    tick();
    n_checks++; if (im_wdata !== 32'hFE208EE3) $display("FAIL beq_neg4: got %h want fe208ee3", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL beq_err_clear: got %b want 0", err); else n_pass++;
    set_req(1'b1, 27, 0, 1, 2, 32'd3);
    tick();
    n_checks++; if (im_wdata !== 32'h00000013) $display("FAIL beq_odd_nop: got %h want 00000013", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL beq_odd_err: got %b want 1", err); else n_pass++;
    set_req(1'b1, 0, 1, 2, 3, 32'd0);
    tick();
    n_checks++; if (im_wdata !== 32'h003100B3) $display("FAIL after_err_add: got %h want 003100b3", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else n_pass++;
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_misc();
    do_reset();
    im_ready = 1'b1;
    set_req(1'b1, 18, 7, 7, 0, 32'd3);
    tick();
    n_checks++; if (im_wdata !== 32'h4033D393) $display("FAIL srai: got %h want 4033d393", im_wdata); else n_pass++;
    set_req(1'b1, 35, 10, 0, 0, 32'h12345000);
    tick();
    n_checks++; if (im_wdata !== 32'h12345537) $display("FAIL lui: got %h want 12345537", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL lui_err: got %b want 0", err); else n_pass++;
    set_req(1'b1, 63, 1, 1, 1, 32'd0);
    tick();
    n_checks++; if (im_wdata !== 32'h00000013) $display("FAIL mn63_nop: got %h want 00000013", im_wdata); else n_pass++;
    n_checks++; if (err !== 1'b1) $display("FAIL mn63_err: got %b want 1", err); else n_pass++;
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    im_ready = 1'b0;
    set_req(1'b1, 10, 1, 0, 0, 32'd5);
    tick();
    n_checks++; if (im_we !== 1'b1 || im_wdata !== 32'h00500093 || im_addr !== 10'h000)
      $display("FAIL bp_first: got we=%b %h@%h want 1 00500093@000", im_we, im_wdata, im_addr); else n_pass++;
    set_req(1'b1, 0, 1, 2, 3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (req_ready !== 1'b0) $display("FAIL bp_ready_%0d: got %b want 0", i, req_ready); else n_pass++;
      tick();
      n_checks++; if (im_we !== 1'b1 || im_wdata !== 32'h00500093 || im_addr !== 10'h000)
        $display("FAIL bp_hold_%0d: got we=%b %h@%h want 1 00500093@000", i, im_we, im_wdata, im_addr); else n_pass++;
    end
    im_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", req_ready); else n_pass++;
    tick();
    n_checks++; if (im_wdata !== 32'h003100B3 || im_addr !== 10'h004 || word_cnt !== 9'd1)
      $display("FAIL bp_second: got %h@%h cnt=%0d want 003100b3@004 cnt=1", im_wdata, im_addr, word_cnt); else n_pass++;
    req_valid = 1'b0;
    tick();
    n_checks++; if (word_cnt !== 9'd2 || im_we !== 1'b0)
      $display("FAIL bp_done: got cnt=%0d we=%b want cnt=2 we=0", word_cnt, im_we); else n_pass++;
  endtask

  task automatic test_wrap_and_start();
    do_reset();
    im_ready = 1'b1;
    for (int k = 0; k < 256; k++) begin
      set_req(1'b1, 10, k % 32, 0, 0, 32'(k));
      tick();
      n_checks++; if (im_addr !== 10'(4 * k))
        $display("FAIL wrap_addr_%0d: got %h want %h", k, im_addr, 10'(4 * k)); else n_pass++;
    end
    n_checks++; if (im_addr !== 10'h3FC || im_wdata !== 32'h0FF00F93)
      $display("FAIL wrap_last: got %h@%h want 0ff00f93@3fc", im_wdata, im_addr); else n_pass++;
    set_req(1'b1, 10, 1, 0, 0, 32'd4096);
    tick();
    n_checks++; if (im_addr !== 10'h000 || im_wdata !== 32'h00000013 || err !== 1'b1 || word_cnt !== 9'd256)
      $display("FAIL wrap_next: got %h@%h err=%b cnt=%0d want 00000013@000 err=1 cnt=256",
               im_wdata, im_addr, err, word_cnt); else n_pass++;
    im_ready = 1'b0;
    start = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL start_ready: got %b want 0", req_ready); else n_pass++;
    tick();
    start = 1'b0;
    req_valid = 1'b0;
    n_checks++; if (im_we !== 1'b0 || im_addr !== 10'h000 || err !== 1'b0 || word_cnt !== 9'd0)
      $display("FAIL start_clear: got we=%b addr=%h err=%b cnt=%0d want 0 000 0 0",
               im_we, im_addr, err, word_cnt); else n_pass++;
    tick();
    n_checks++; if (im_we !== 1'b0) $display("FAIL start_no_accept: got %b want 0", im_we); else n_pass++;
  endtask

  task automatic test_random();
    int edges[15];
    int imm;
    logic exp_rdy;
    edges = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097,
              (1 << 20) - 2, 1 << 20, -(1 << 20), 31, 32, 0};
    do_reset();
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 5))
        0: imm = int'($urandom_range(0, 4095)) - 2048;
        1: imm = edges[$urandom_range(0, 14)];
        2: imm = int'($urandom);
        3: imm = (int'($urandom_range(0, 10000)) - 5000) & ~1;
        4: imm = int'($urandom_range(0, 40));
        default: imm = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
      endcase
      set_req($urandom_range(0, 3) != 0, ($urandom_range(0, 20) == 0) ? 63 : int'($urandom_range(0, 39)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 32'(imm));
      im_ready = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 39) == 0;
      #1;
      exp_rdy = !start && (!m_we || im_ready);
      n_checks++; if (req_ready !== exp_rdy)
        $display("FAIL rnd_ready_%0d: got %b want %b", c, req_ready, exp_rdy); else n_pass++;
      tick();
      n_checks++; if (im_we !== m_we) $display("FAIL rnd_we_%0d: got %b want %b", c, im_we, m_we); else n_pass++;
      if (m_we) begin
        n_checks++; if (im_addr !== m_addr[9:0] || im_wdata !== m_word)
          $display("FAIL rnd_word_%0d: got %h@%h want %h@%h", c, im_wdata, im_addr, m_word, m_addr[9:0]); else n_pass++;
      end
      n_checks++; if (err !== m_err || word_cnt !== m_cnt[8:0])
        $display("FAIL rnd_flags_%0d: got err=%b cnt=%0d want err=%b cnt=%0d", c, err, word_cnt, m_err, m_cnt); else n_pass++;
    end
    start = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; im_ready = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 32'd0);
    test_reset();
    test_add();
    test_back_to_back();
    test_branch_err();
    test_misc();
    test_backpressure();
    test_wrap_and_start();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
